// File: rtl/population_pattern_gen_if.sv
// Command and stream bundle for population_pattern_gen: start/k/abort in, word stream and status out.
interface population_pattern_gen_if #(
  parameter int W  = 32,
  parameter int CW = $clog2(W + 1)
);
  logic          start;
  logic [CW-1:0] k;
  logic          abort;
  logic          out_ready;
  logic          out_valid;
  logic [W-1:0]  word;
  logic          last;
  logic          busy;
  logic          done;
  logic          err;

  modport master (
    input  start, k, abort, out_ready,
    output out_valid, word, last, busy, done, err
  );

  modport slave (
    output start, k, abort, out_ready,
    input  out_valid, word, last, busy, done, err
  );
endinterface

// File: rtl/population_pattern_gen.sv
// Streams every W-bit word with exactly k ones, ascending, one per accepted handshake.
// Optional POP_GEN_SELFCHECK_EN adds a sticky chk_err output (popcount and hold-stability monitor).
module population_pattern_gen #(
  parameter int W  = 32,
  parameter int CW = $clog2(W + 1)
) (
  input  logic clk,
  input  logic rst,
  population_pattern_gen_if.master bus
`ifdef POP_GEN_SELFCHECK_EN
  ,
  output logic chk_err
`endif
);

  localparam logic [CW-1:0] KMAX = CW'(W);

  typedef enum logic [1:0] {IDLE, EMIT, DONE} state_t;

  state_t        state_q;
  logic [W-1:0]  word_q;
  logic [CW-1:0] k_q;
  logic          valid_q;
  logic          last_q;
  logic          busy_q;
  logic          done_q;
  logic          err_q;
  logic [W-1:0]  word_d;
  logic          last_d;

  function automatic logic [W-1:0] low_mask(input logic [CW-1:0] n);
    return (W'(1) << n) - W'(1);
  endfunction

  function automatic logic [W-1:0] top_mask(input logic [CW-1:0] n);
    return low_mask(n) << (KMAX - n);
  endfunction

  function automatic logic [CW-1:0] ctz(input logic [W-1:0] x);
    ctz = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (x[i]) ctz = CW'(i);
    end
  endfunction

  // Gosper step; c is a power of two so the divide becomes a shift by ctz(c).
  function automatic logic [W-1:0] next_pattern(input logic [W-1:0] x);
    logic [W-1:0] c;
    logic [W-1:0] r;
    c = x & (~x + W'(1));
    r = x + c;
    return r | (((r ^ x) >> 2) >> ctz(c));
  endfunction

  always_comb begin
    word_d = next_pattern(word_q);
    last_d = (word_d == top_mask(k_q));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      word_q  <= '0;
      k_q     <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            if (bus.k > KMAX) begin
              err_q <= 1'b1;
            end else begin
              k_q     <= bus.k;
              word_q  <= low_mask(bus.k);
              last_q  <= (bus.k == '0) || (bus.k == KMAX);
              valid_q <= 1'b1;
              busy_q  <= 1'b1;
              state_q <= EMIT;
            end
          end
        end
        EMIT: begin
          // abort wins over a simultaneous accept: that word is dropped
          if (bus.abort) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (bus.out_ready) begin
            if (last_q) begin
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              word_q <= word_d;
              last_q <= last_d;
            end
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.word      = word_q;
  assign bus.last      = last_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

`ifdef POP_GEN_SELFCHECK_EN
  logic         chk_err_q;
  logic         stall_q;
  logic [W-1:0] word_prev_q;

  function automatic logic [CW-1:0] popcnt(input logic [W-1:0] x);
    popcnt = '0;
    for (int i = 0; i < W; i++) popcnt = popcnt + CW'(x[i]);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chk_err_q   <= 1'b0;
      stall_q     <= 1'b0;
      word_prev_q <= '0;
    end else begin
      stall_q     <= valid_q & ~bus.out_ready;
      word_prev_q <= word_q;
      if ((valid_q && (popcnt(word_q) != k_q)) || (stall_q && (word_q != word_prev_q)))
        chk_err_q <= 1'b1;
    end
  end

  assign chk_err = chk_err_q;
`endif

endmodule

// File: tb/tb_population_pattern_gen.sv
// Self-checking bench for population_pattern_gen at W=8 and W=32 against an enumerating reference model.
module tb_population_pattern_gen;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  population_pattern_gen_if #(.W(8))  b8 ();
  population_pattern_gen_if #(.W(32)) b32 ();

`ifdef POP_GEN_SELFCHECK_EN
  logic chk8;
  logic chk32;
`endif

  population_pattern_gen #(.W(8)) dut8 (
    .clk(clk), .rst(rst), .bus(b8)
`ifdef POP_GEN_SELFCHECK_EN
    , .chk_err(chk8)
`endif
  );

  population_pattern_gen #(.W(32)) dut32 (
    .clk(clk), .rst(rst), .bus(b32)
`ifdef POP_GEN_SELFCHECK_EN
    , .chk_err(chk32)
`endif
  );

  typedef struct {
    int         k;
    bit         rnd;
    int         abort_at;
    int         exp_cnt;
    logic [7:0] exp_first;
    logic [7:0] exp_final;
    bit         exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int binom(input int n, input int r);
    longint acc = 1;
    for (int i = 1; i <= r; i++) acc = acc * (n - r + i) / i;
    return int'(acc);
  endfunction

  task automatic run8(input int kk, input bit rnd, input int abort_at,
                      output int nacc, output logic [7:0] fw, output logic [7:0] lw,
                      output bit saw_err);
    logic [7:0] exp_q[$];
    logic [7:0] w_now;
    int cyc;
    bit fin;
    bit rdy;
    bit ab;
    exp_q = {};
    nacc = 0; fw = '0; lw = '0; saw_err = 1'b0; cyc = 0; fin = 1'b0;
    for (int v = 0; v < 256; v++) if ($countones(8'(v)) == kk) exp_q.push_back(8'(v));
    b8.start = 1'b1;
    b8.k     = 4'(kk);
    @(negedge clk);
    b8.start = 1'b0;
    saw_err  = b8.err;
    if (kk > 8) begin
      chk("err_valid", b8.out_valid, 0);
      chk("err_busy", b8.busy, 0);
      @(negedge clk);
      chk("err_pulse_width", b8.err, 0);
      chk("err_idle_valid", b8.out_valid, 0);
      return;
    end
    while (!fin) begin
      if (cyc >= 3000) begin
        chk("stream8_timeout", nacc, exp_q.size());
        break;
      end
      w_now = b8.word;
      chk("valid8", b8.out_valid, 1);
      chk("word8", w_now, exp_q[nacc]);
      chk("last8", b8.last, nacc == exp_q.size() - 1);
      rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      ab  = (nacc == abort_at);
      if (ab) rdy = 1'b1;
      b8.out_ready = rdy;
      b8.abort     = ab;
      b8.start     = 1'($urandom_range(0, 1));
      b8.k         = 4'($urandom);
      @(negedge clk);
      b8.abort = 1'b0;
      b8.start = 1'b0;
      cyc++;
      if (ab) begin
        chk("abort_valid", b8.out_valid, 0);
        chk("abort_done", b8.done, 0);
        chk("abort_busy", b8.busy, 0);
        fin = 1'b1;
      end else if (rdy) begin
        if (nacc == 0) fw = w_now;
        lw = w_now;
        nacc++;
        if (nacc == exp_q.size()) begin
          chk("done_pulse", b8.done, 1);
          chk("done_valid", b8.out_valid, 0);
          chk("done_busy", b8.busy, 1);
          @(negedge clk);
          chk("done_width", b8.done, 0);
          chk("idle_busy", b8.busy, 0);
          fin = 1'b1;
        end
      end
    end
  endtask

  task automatic run32(input int kk, output int nacc);
    logic [31:0] exp_q[$];
    int cyc;
    bit fin;
    bit rdy;
    exp_q = {};
    nacc = 0; cyc = 0; fin = 1'b0;
    if (kk == 0) exp_q.push_back(32'h0);
    else if (kk == 32) exp_q.push_back(32'hFFFF_FFFF);
    else if (kk == 1) for (int b = 0; b < 32; b++) exp_q.push_back(32'd1 << b);
    else if (kk == 31) for (int b = 31; b >= 0; b--) exp_q.push_back(~(32'd1 << b));
    else if (kk == 2)
      for (int j = 1; j < 32; j++) for (int i = 0; i < j; i++) exp_q.push_back((32'd1 << j) | (32'd1 << i));
    b32.start = 1'b1;
    b32.k     = 6'(kk);
    @(negedge clk);
    b32.start = 1'b0;
    chk("start32_err", b32.err, 0);
    while (!fin) begin
      if (cyc >= 3000) begin
        chk("stream32_timeout", nacc, exp_q.size());
        break;
      end
      chk("valid32", b32.out_valid, 1);
      chk("word32", b32.word, exp_q[nacc]);
      chk("last32", b32.last, nacc == exp_q.size() - 1);
      rdy = 1'($urandom_range(0, 3) != 0);
      b32.out_ready = rdy;
      @(negedge clk);
      cyc++;
      if (rdy) begin
        nacc++;
        if (nacc == exp_q.size()) begin
          chk("done32_pulse", b32.done, 1);
          chk("done32_valid", b32.out_valid, 0);
          @(negedge clk);
          chk("idle32_busy", b32.busy, 0);
          fin = 1'b1;
        end
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int nacc;
    int kk;
    logic [7:0] fw;
    logic [7:0] lw;
    bit saw_err;

    vecs.push_back('{0, 1'b0, -1, 1,  8'h00, 8'h00, 1'b0});
    vecs.push_back('{1, 1'b0, -1, 8,  8'h01, 8'h80, 1'b0});
    vecs.push_back('{2, 1'b1, -1, 28, 8'h03, 8'hC0, 1'b0});
    vecs.push_back('{3, 1'b1, -1, 56, 8'h07, 8'hE0, 1'b0});
    vecs.push_back('{4, 1'b0, 4,  4,  8'h0F, 8'h1D, 1'b0});
    vecs.push_back('{1, 1'b0, -1, 8,  8'h01, 8'h80, 1'b0});
    vecs.push_back('{4, 1'b1, -1, 70, 8'h0F, 8'hF0, 1'b0});
    vecs.push_back('{7, 1'b1, -1, 8,  8'h7F, 8'hFE, 1'b0});
    vecs.push_back('{8, 1'b0, -1, 1,  8'hFF, 8'hFF, 1'b0});
    vecs.push_back('{9, 1'b0, -1, 0,  8'h00, 8'h00, 1'b1});
    vecs.push_back('{15, 1'b0, -1, 0, 8'h00, 8'h00, 1'b1});

    rst = 1'b1;
    b8.start = 1'b0;  b8.k = '0;  b8.abort = 1'b0;  b8.out_ready = 1'b0;
    b32.start = 1'b0; b32.k = '0; b32.abort = 1'b0; b32.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid", b8.out_valid, 0);
    chk("rst_word", b8.word, 0);
    chk("rst_busy", b8.busy, 0);
    chk("rst_done", b8.done, 0);
    chk("rst_err", b8.err, 0);
    chk("rst_word32", b32.word, 0);
    rst = 1'b0;
    @(negedge clk);

    // idle: ready and abort without a stream do nothing
    b8.out_ready = 1'b1;
    b8.abort     = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_ready_valid", b8.out_valid, 0);
    chk("idle_abort_busy", b8.busy, 0);
    b8.abort = 1'b0;

    foreach (vecs[i]) begin
      run8(vecs[i].k, vecs[i].rnd, vecs[i].abort_at, nacc, fw, lw, saw_err);
      chk($sformatf("vec%0d_cnt", i), nacc, vecs[i].exp_cnt);
      chk($sformatf("vec%0d_err", i), saw_err, vecs[i].exp_err);
      if (vecs[i].exp_cnt > 0) begin
        chk($sformatf("vec%0d_first", i), fw, vecs[i].exp_first);
        chk($sformatf("vec%0d_final", i), lw, vecs[i].exp_final);
      end
    end

    for (int t = 0; t < 6; t++) begin
      kk = $urandom_range(0, 8);
      run8(kk, 1'b1, -1, nacc, fw, lw, saw_err);
      chk($sformatf("rand_k%0d_cnt", kk), nacc, binom(8, kk));
    end

    run32(0, nacc);
    chk("w32_k0_cnt", nacc, 1);
    run32(32, nacc);
    chk("w32_k32_cnt", nacc, 1);
    run32(31, nacc);
    chk("w32_k31_cnt", nacc, 32);
    run32(2, nacc);
    chk("w32_k2_cnt", nacc, binom(32, 2));

    b32.start = 1'b1;
    b32.k     = 6'd33;
    @(negedge clk);
    b32.start = 1'b0;
    chk("w32_k33_err", b32.err, 1);
    chk("w32_k33_valid", b32.out_valid, 0);
    @(negedge clk);
    chk("w32_k33_err_width", b32.err, 0);
    chk("w32_k33_busy", b32.busy, 0);

    // asynchronous reset mid-stream
    b8.start = 1'b1;
    b8.k     = 4'd4;
    @(negedge clk);
    b8.start     = 1'b0;
    b8.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("pre_rst_word", b8.word, 8'h1D);
`ifdef POP_GEN_SELFCHECK_EN
    chk("chk_err8_pre_rst", chk8, 0);
    chk("chk_err32_pre_rst", chk32, 0);
`endif
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", b8.out_valid, 0);
    chk("arst_word", b8.word, 0);
    chk("arst_busy", b8.busy, 0);
    chk("arst_last", b8.last, 0);
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_valid", b8.out_valid, 0);
    chk("post_rst_done", b8.done, 0);
    run8(8, 1'b0, -1, nacc, fw, lw, saw_err);
    chk("post_rst_k8_cnt", nacc, 1);
    chk("post_rst_k8_word", fw, 8'hFF);
`ifdef POP_GEN_SELFCHECK_EN
    chk("chk_err8_end", chk8, 0);
    chk("chk_err32_end", chk32, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
